// File: rtl/clk_activity_monitor.sv
// Multi-channel clock-activity monitor: synchronises NUM_CH nets into clk, counts rising
// edges over a fixed window and reports saturated counts with in-range and stuck flags.
module clk_activity_monitor #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       mon_in,
  input  logic [NUM_CH*CNT_W-1:0] exp_min,
  input  logic [NUM_CH*CNT_W-1:0] exp_max,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic                    valid,
  output logic [NUM_CH-1:0]       in_range,
  output logic [NUM_CH-1:0]       stuck,
  output logic                    busy
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_CH-1:0]       r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]       r_hist;
  logic [NUM_CH-1:0]       w_rise;
  logic [WIN_W-1:0]        r_win;
  logic                    w_run;
  logic                    w_last;
  logic [CNT_W-1:0]        r_cnt     [NUM_CH];
  logic [CNT_W-1:0]        w_cnt_nxt [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] r_cnt_out;
  logic                    r_valid;
  logic [NUM_CH-1:0]       r_in_range;
  logic [NUM_CH-1:0]       r_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge
      // value, which is what turns these flops into a shift chain.
      r_sync[0] <= mon_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: the default comes first so every path assigns w_state_nxt and no latch forms.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en)  w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy   = (r_state == RUN);
  assign w_run  = busy && en;
  assign w_last = w_run && (r_win == WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_win <= '0;
    else        r_win <= (w_run && !w_last) ? r_win + 1'b1 : '0;
  end

  // The closing cycle's own edge is folded in here so it lands in the closing window.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = (r_cnt[i] == CNT_MAX) ? CNT_MAX : r_cnt[i] + CNT_W'(w_rise[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is ordinary flops, not a RAM, so it is cleared with the rest.
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      r_cnt_out  <= '0;
      r_in_range <= '0;
      r_stuck    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_last;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= (w_run && !w_last) ? w_cnt_nxt[i] : '0;
        if (w_last) begin
          r_cnt_out[i*CNT_W +: CNT_W] <= w_cnt_nxt[i];
          r_in_range[i] <= (w_cnt_nxt[i] >= exp_min[i*CNT_W +: CNT_W]) &&
                           (w_cnt_nxt[i] <= exp_max[i*CNT_W +: CNT_W]);
          r_stuck[i]    <= (w_cnt_nxt[i] == '0);
        end
      end
    end
  end

  assign cnt_out  = r_cnt_out;
  assign valid    = r_valid;
  assign in_range = r_in_range;
  assign stuck    = r_stuck;

endmodule
